// File: rtl/pc_pkg.sv
// Shared defaults and the fetch-target select encoding for the program-counter unit.
package pc_pkg;

  localparam int          DEF_AW        = 17;
  localparam logic [16:0] DEF_RESET_VEC = 17'h00000;
  localparam logic [16:0] DEF_IRQ_VEC   = 17'h00010;

  typedef enum logic [2:0] {
    SEL_NXT,
    SEL_DST,
    SEL_RAS,
    SEL_EPC,
    SEL_IRQ
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace with occupancy and sticky error flags.
module pc_ras
  import pc_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] link,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  logic [AW-1:0] stack [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [CW-1:0] count;

  assign ptr_inc = ptr + PTR_ONE;
  assign top     = stack[ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);

  // ptr always addresses the top entry; a push into a full stack lands on the oldest slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (pop && empty) unf <= 1'b1;
      if (push && pop && !empty) begin
        stack[ptr] <= link;
      end else if (push) begin
        stack[ptr_inc] <= link;
        ptr            <= ptr_inc;
        if (full) ovf   <= 1'b1;
        else      count <= count + CNT_ONE;
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: fetch address, PC+1 tap pipeline, return-address stack,
// and single-level interrupt entry/return with saved EPC.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter logic [AW-1:0] RESET_VEC  = AW'(DEF_RESET_VEC),
  parameter logic [AW-1:0] IRQ_VEC    = AW'(DEF_IRQ_VEC),
  parameter int            RAS_DEPTH  = 4,
  parameter int            PIPE_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_IM_ID,
  input  logic                     flow_change_ID_EX,
  input  logic [AW-1:0]            dst_ID_EX,
  input  logic                     call_ID_EX,
  input  logic                     ret_ID_EX,
  input  logic                     reti_ID_EX,
  input  logic                     irq,
  output logic [AW-1:0]            pc,
  output logic [PIPE_DEPTH*AW-1:0] pc_taps,
  output logic [AW-1:0]            epc,
  output logic                     in_isr,
  output logic                     irq_ack,
  output logic                     ras_empty,
  output logic                     ras_full,
  output logic                     ras_ovf,
  output logic                     ras_unf
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] nxt_pc;
  logic [AW-1:0] resume_pc;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] epc_q;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] taps [PIPE_DEPTH];
  logic          in_isr_q;
  logic          irq_ack_q;
  logic          irq_take;
  logic          ras_push;
  logic          ras_pop;
  pc_sel_e       sel;
  pc_sel_e       fetch_sel;

  assign nxt_pc   = pc_q + AW'(1);
  assign ras_push = call_ID_EX & flow_change_ID_EX & ~stall_IM_ID;
  assign ras_pop  = ret_ID_EX & ~stall_IM_ID;
  assign irq_take = irq & ~in_isr_q & ~stall_IM_ID & ~reti_ID_EX;

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .link  (taps[1]),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  // resume_pc is where execution continues; an accepted interrupt parks it in EPC instead
  always_comb begin
    sel = SEL_NXT;
    if (reti_ID_EX)                  sel = SEL_EPC;
    else if (ret_ID_EX && !ras_empty) sel = SEL_RAS;
    else if (ret_ID_EX || flow_change_ID_EX) sel = SEL_DST;

    unique case (sel)
      SEL_EPC: resume_pc = epc_q;
      SEL_RAS: resume_pc = ras_top;
      SEL_DST: resume_pc = dst_ID_EX;
      default: resume_pc = nxt_pc;
    endcase

    fetch_sel = irq_take ? SEL_IRQ : sel;
    pc_d      = (fetch_sel == SEL_IRQ) ? IRQ_VEC : resume_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      in_isr_q  <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= irq_take;
      if (!stall_IM_ID) begin
        pc_q <= pc_d;
        if (irq_take) begin
          epc_q    <= resume_pc;
          in_isr_q <= 1'b1;
        end else if (reti_ID_EX) begin
          in_isr_q <= 1'b0;
        end
      end
    end
  end

  // Only tap0 honours the stall; downstream taps keep draining with the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_DEPTH; k++) taps[k] <= '0;
    end else begin
      if (!stall_IM_ID) taps[0] <= nxt_pc;
      for (int k = 1; k < PIPE_DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

  for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_taps
    assign pc_taps[g*AW +: AW] = taps[g];
  end

  assign pc      = pc_q;
  assign epc     = epc_q;
  assign in_isr  = in_isr_q;
  assign irq_ack = irq_ack_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter unit for the pipelined CPU: generates the fetch address and pipelines PC+1 down a configurable number of stages. It adds a return-address stack for call/return target prediction and a single-level interrupt entry/return mechanism with a saved EPC. It sits between the EX-stage branch resolution logic and instruction memory, and feeds the ID_EX/EX_DM PC consumers (branch adder, JAL link mux).

## Interface
- AW, 17, PC/address width in bits
- RESET_VEC, 0, PC value after reset
- IRQ_VEC, 'h00010, PC loaded on interrupt entry
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2
- PIPE_DEPTH, 3, number of PC+1 pipeline taps; ≥2 (tap0 = IM_ID, tap1 = ID_EX, tap2 = EX_DM, …)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_IM_ID  in  1  freezes PC, tap0, RAS, EPC and interrupt acceptance
- flow_change_ID_EX  in  1  taken branch/jump resolved in EX
- dst_ID_EX  in  AW  branch/jump target
- call_ID_EX  in  1  qualifies flow_change as a call; push link onto RAS
- ret_ID_EX  in  1  return; target taken from RAS top instead of dst
- reti_ID_EX  in  1  return from interrupt; target = EPC
- irq  in  1  level interrupt request, held by source until irq_ack
- pc  out  AW  fetch address
- pc_taps  out  PIPE_DEPTH*AW  packed taps, tap k at bits [k*AW +: AW]
- epc  out  AW  saved resume address
- in_isr  out  1  interrupt in service
- irq_ack  out  1  one-cycle pulse on interrupt acceptance
- ras_empty, ras_full  out  1 each  RAS occupancy flags
- ras_ovf, ras_unf  out  1 each  sticky error flags, cleared only by reset

## Operation
- Reset: pc=RESET_VEC; taps, epc=0; in_isr, irq_ack, ras_ovf, ras_unf=0; RAS count=0 (ras_empty=1).
- nxt_pc = pc+1, modulo 2^AW (wraps all-ones→0).
- Target select (not stalled), priority high→low: reti → epc; ret with RAS non-empty → RAS top; ret with RAS empty → dst_ID_EX, set ras_unf; flow_change → dst_ID_EX; else nxt_pc.
- Interrupt accept: irq & !in_isr & !stall_IM_ID & !reti_ID_EX. Then pc←IRQ_VEC, epc←selected target above, in_isr←1, irq_ack pulses next cycle. Any call/ret in the same cycle still updates the RAS.
- reti (not stalled): pc←epc, in_isr←0; irq re-acceptable from the following cycle.
- RAS push: call_ID_EX & flow_change_ID_EX & !stall; link = tap1 (ID_EX PC+1). Full push overwrites oldest entry (circular), count stays RAS_DEPTH, set ras_ovf.
- RAS pop: ret_ID_EX & !stall & non-empty; count−1.
- call & ret same cycle: target = old top; top replaced with link; count unchanged; empty → plain push plus ras_unf.
- call/ret/reti without flow_change: call ignored; ret and reti act on their own.
- Stall: pc, tap0, RAS, epc, in_isr frozen; irq held off; flow_change/call/ret/reti ignored (EX stage holds them).

## Timing
- pc updates one cycle after the qualifying inputs; zero-cycle combinational path from RAS top/epc to the pc D-input only.
- tap0←nxt_pc when !stall_IM_ID; tap k←tap k−1 every cycle, unconditionally.
- RAS top visible to ret the cycle after a push (no bypass of same-cycle push except call&ret case above).
- irq_ack asserted exactly one cycle, the cycle after acceptance; epc/in_isr valid the same cycle.
- rst_n assertion mid-operation clears all state immediately, including pending in_isr and RAS contents.

## Structure
- Package pc_pkg: default AW, RESET_VEC, IRQ_VEC, target-select enum (SEL_NXT, SEL_DST, SEL_RAS, SEL_EPC, SEL_IRQ).
- Sub-module pc_ras: circular RAS_DEPTH×AW stack with push/pop/replace, count, empty/full, ovf/unf; pc_ctrl holds PC, taps, EPC and interrupt control.

## Test plan
- Reset then 5 free-run cycles → pc = 0,1,2,3,4,5; tap0 = prior pc+1; tap2 lags tap0 by 2.
- flow_change with dst='h00100 at pc=7 → pc='h00100 next cycle; stall held 3 cycles → pc, tap0 frozen, tap1/tap2 keep shifting.
- call with tap1=8 then ret 4 cycles later with dst='h1FFFF → pc=8, ras_empty=1, ras_unf=0.
- 5 calls (links 1..5) with RAS_DEPTH=4 → ras_ovf=1; 4 rets → pc=5,4,3,2; 5th ret with dst='h00040 → pc='h00040, ras_unf=1.
- irq at pc='h00020, no flow change → pc=IRQ_VEC, epc='h00021, irq_ack one pulse; second irq ignored until reti → pc='h00021, in_isr=0.
- irq same cycle as flow_change dst='h00300 → pc=IRQ_VEC, epc='h00300; pc='h1FFFF free-run → wraps to 0.
